// File: rtl/riscv_lsu_pkg.sv
// Shared encodings and lane helpers for the riscv_lsu load/store sequencer.
// Imported by the top and its load-alignment sub-module.
package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } lsu_state_t;

    // Sizes 3, 6 and 7 are illegal and are reported together with misalignment.
    function automatic logic lsu_legal(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: return 1'b1;
            LDST_H, LDST_HU: return ~off[0];
            LDST_W:          return off == 2'b00;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lsu_store_be(input logic       we,
                                                input logic [2:0] size,
                                                input logic [1:0] off);
        if (!we) return 4'b1111;
        case (size)
            LDST_B, LDST_BU: return 4'b0001 << off;
            LDST_H, LDST_HU: return off[1] ? 4'b1100 : 4'b0011;
            default:         return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lsu_store_wd(input logic [2:0] size, input logic [31:0] wd);
        case (size)
            LDST_B, LDST_BU: return {4{wd[7:0]}};
            LDST_H, LDST_HU: return {2{wd[15:0]}};
            default:         return wd;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_load_align.sv
// Extracts the addressed byte/half lane from a memory word and extends it
// to 32 bits (signed for B/H, zero for BU/HU, word passed through).
module lsu_load_align
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        data_o    = word_i;
        byte_lane = word_i[{off_i, 3'b000} +: 8];
        half_lane = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (size_i)
            LDST_B:  data_o = {{24{byte_lane[7]}}, byte_lane};
            LDST_BU: data_o = {24'd0, byte_lane};
            LDST_H:  data_o = {{16{half_lane[15]}}, half_lane};
            LDST_HU: data_o = {16'd0, half_lane};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store sequencer: checks alignment, drives a word-addressed memory with
// byte enables, waits for ready with a timeout, and owns the core stall.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [31:0]       core_wd_i,
    output logic [31:0]       core_rd_o,
    output logic              core_stall_o,
    output logic              core_misalign_o,
    output logic              core_bus_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wd_o,
    input  logic [31:0]       mem_rd_i,
    input  logic              mem_ready_i
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [2:0]         size_q, size_d;
    logic [1:0]         off_q, off_d;
    logic [ADDR_W-3:0]  waddr_q, waddr_d;
    logic [31:0]        wd_q, wd_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        rd_q, rd_d;
    logic               misalign_q, misalign_d;
    logic               bus_err_q, bus_err_d;
    logic [31:0]        load_data;

    lsu_load_align u_load_align (
        .word_i (mem_rd_i),
        .size_i (size_q),
        .off_i  (off_q),
        .data_o (load_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        off_d      = off_q;
        waddr_d    = waddr_q;
        wd_d       = wd_q;
        be_d       = be_q;
        rd_d       = rd_q;
        misalign_d = misalign_q;
        bus_err_d  = bus_err_q;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    if (lsu_legal(core_size_i, core_addr_i[1:0])) begin
                        we_d    = core_we_i;
                        size_d  = core_size_i;
                        off_d   = core_addr_i[1:0];
                        waddr_d = core_addr_i[ADDR_W-1:2];
                        wd_d    = lsu_store_wd(core_size_i, core_wd_i);
                        be_d    = lsu_store_be(core_we_i, core_size_i, core_addr_i[1:0]);
                        cnt_d   = '0;
                        state_d = ACCESS;
                    end else begin
                        misalign_d = 1'b1;
                        rd_d       = '0;
                        state_d    = DONE;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // Ready takes priority over a timeout landing in the same cycle.
                if (mem_ready_i) begin
                    rd_d    = we_q ? '0 : load_data;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_err_d = 1'b1;
                    rd_d      = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                misalign_d = 1'b0;
                bus_err_d  = 1'b0;
                cnt_d      = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            off_q      <= '0;
            waddr_q    <= '0;
            wd_q       <= '0;
            be_q       <= '0;
            rd_q       <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            size_q     <= size_d;
            off_q      <= off_d;
            waddr_q    <= waddr_d;
            wd_q       <= wd_d;
            be_q       <= be_d;
            rd_q       <= rd_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign core_rd_o       = rd_q;
    assign core_stall_o    = core_req_i && (state_q != DONE);
    assign core_misalign_o = misalign_q;
    assign core_bus_err_o  = bus_err_q;
    assign mem_req_o       = (state_q == ACCESS);
    assign mem_we_o        = we_q;
    assign mem_be_o        = be_q;
    assign mem_addr_o      = {waddr_q, 2'b00};
    assign mem_wd_o        = wd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: a transaction-level model predicts every
// cycle's outputs, and literal expectations pin the model on key vectors.
module tb_riscv_lsu;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i, core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i, core_wd_i, core_rd_o;
    logic        core_stall_o, core_misalign_o, core_bus_err_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
    logic        mem_ready_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Per-cycle expectations, written by the driver and checked on the falling edge.
    bit          chk = 0, chk_mem = 0;
    logic        exp_req, exp_stall, exp_mis, exp_err, exp_we;
    logic [31:0] exp_rd, exp_addr, exp_wd, last_rd;
    logic [3:0]  exp_be;
    int          stall_cnt, req_cnt, err_cnt, mis_cnt;

    riscv_lsu #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .core_req_i      (core_req_i),
        .core_we_i       (core_we_i),
        .core_size_i     (core_size_i),
        .core_addr_i     (core_addr_i),
        .core_wd_i       (core_wd_i),
        .core_rd_o       (core_rd_o),
        .core_stall_o    (core_stall_o),
        .core_misalign_o (core_misalign_o),
        .core_bus_err_o  (core_bus_err_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wd_o        (mem_wd_o),
        .mem_rd_i        (mem_rd_i),
        .mem_ready_i     (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model ----
    function automatic bit m_legal(input logic [2:0] size, input logic [31:0] addr);
        int bytes;
        case (size)
            3'd0, 3'd4: bytes = 1;
            3'd1, 3'd5: bytes = 2;
            3'd2:       bytes = 4;
            default:    return 1'b0;
        endcase
        return (addr % bytes) == 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [2:0] size,
                                           input logic [31:0] addr);
        logic [31:0] b, h;
        b = (word >> (8 * (addr % 4))) & 32'hFF;
        h = (word >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
        case (size)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input bit we, input logic [2:0] size, input logic [31:0] addr);
        if (!we) return 4'd15;
        case (size)
            3'd0, 3'd4: return 4'(1 << (addr % 4));
            3'd1, 3'd5: return 4'(3 << (addr % 4));
            default:    return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] size, input logic [31:0] wd);
        case (size)
            3'd0, 3'd4: return (wd & 32'hFF) * 32'h0101_0101;
            3'd1, 3'd5: return (wd & 32'hFFFF) * 32'h0001_0001;
            default:    return wd;
        endcase
    endfunction

    task automatic exp_idle();
        exp_req = 0; exp_stall = 0; exp_mis = 0; exp_err = 0; chk_mem = 0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One core access; ready_at is the ACCESS cycle index with mem_ready_i, or -1 for never.
    task automatic access(input bit we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rword, input int ready_at);
        bit legal, ok;
        int n_acc;
        legal = m_legal(size, addr);
        ok    = (ready_at >= 0) && (ready_at < TO);
        n_acc = ok ? ready_at + 1 : TO;
        stall_cnt = 0; req_cnt = 0; err_cnt = 0; mis_cnt = 0;
        core_req_i = 1; core_we_i = we; core_size_i = size; core_addr_i = addr; core_wd_i = wd;
        exp_idle(); exp_stall = 1;
        step();
        if (legal) begin
            for (int k = 0; k < n_acc; k++) begin
                // Core fields are ignored outside IDLE; scramble them.
                core_we_i = 1'($urandom); core_size_i = 3'($urandom);
                core_addr_i = $urandom; core_wd_i = $urandom;
                mem_ready_i = (k == ready_at);
                mem_rd_i    = (k == ready_at) ? rword : $urandom;
                exp_req = 1; exp_stall = 1; chk_mem = 1;
                exp_we = we; exp_be = m_be(we, size, addr);
                exp_addr = addr & ~32'd3; exp_wd = m_wd(size, wd);
                step();
            end
            mem_ready_i = 0; mem_rd_i = $urandom;
            last_rd = (ok && !we) ? m_load(rword, size, addr) : 32'd0;
            exp_idle(); exp_err = !ok;
        end else begin
            last_rd = 32'd0;
            exp_idle(); exp_mis = 1;
        end
        exp_rd = last_rd;
        step();
        core_req_i = 0;
        exp_idle();
        step();
    endtask

    always @(negedge clk_i) begin
        if (chk) begin
            check("stall", core_stall_o, exp_stall);
            check("mem_req", mem_req_o, exp_req);
            check("misalign", core_misalign_o, exp_mis);
            check("bus_err", core_bus_err_o, exp_err);
            check("core_rd", core_rd_o, exp_rd);
            if (chk_mem) begin
                check("mem_we", mem_we_o, exp_we);
                check("mem_be", mem_be_o, exp_be);
                check("mem_addr", mem_addr_o, exp_addr);
                if (exp_we) check("mem_wd", mem_wd_o, exp_wd);
            end
            if (core_stall_o)    stall_cnt++;
            if (mem_req_o)       req_cnt++;
            if (core_bus_err_o)  err_cnt++;
            if (core_misalign_o) mis_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1; core_req_i = 0; core_we_i = 0; core_size_i = 0; core_addr_i = 0;
        core_wd_i = 0; mem_rd_i = 0; mem_ready_i = 0;
        last_rd = 0; exp_rd = 0; exp_idle();
        #12;
        check("rst core_rd", core_rd_o, 32'd0);
        check("rst mem_req", mem_req_o, 1'b0);
        check("rst mem_be", mem_be_o, 4'd0);
        check("rst mem_addr", mem_addr_o, 32'd0);
        check("rst stall", core_stall_o, 1'b0);
        step();
        rst_i = 0;
        chk = 1;
        step();

        access(0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        check("LW result", core_rd_o, 32'hDEADBEEF);
        check("LW stall cycles", stall_cnt, 2);
        check("LW req cycles", req_cnt, 1);

        access(0, 3'd0, 32'h13, 32'h0, 32'h80AA_BBCC, 0);
        check("LB result", core_rd_o, 32'hFFFF_FF80);
        access(0, 3'd4, 32'h13, 32'h0, 32'h80AA_BBCC, 1);
        check("LBU result", core_rd_o, 32'h0000_0080);

        access(1, 3'd1, 32'h22, 32'h1234_ABCD, 32'hFFFF_FFFF, 1);
        check("SH result", core_rd_o, 32'd0);

        access(0, 3'd2, 32'h06, 32'h0, 32'h1111_1111, 0);
        check("LW mis rd", core_rd_o, 32'd0);
        check("LW mis req", req_cnt, 0);
        check("LW mis pulse", mis_cnt, 1);
        check("LW mis stall", stall_cnt, 1);
        access(0, 3'd3, 32'h08, 32'h0, 32'h1111_1111, 0);
        check("size3 pulse", mis_cnt, 1);
        check("size3 req", req_cnt, 0);

        access(0, 3'd2, 32'h40, 32'h0, 32'h5555_5555, -1);
        check("timeout req cycles", req_cnt, TO);
        check("timeout err pulse", err_cnt, 1);
        check("timeout rd", core_rd_o, 32'd0);
        access(0, 3'd2, 32'h44, 32'h0, 32'hCAFE_F00D, TO - 1);
        check("late ready err", err_cnt, 0);
        check("late ready rd", core_rd_o, 32'hCAFE_F00D);

        access(0, 3'd1, 32'h02, 32'h0, 32'h8001_7FFF, 2);
        check("LH result", core_rd_o, 32'hFFFF_8001);
        access(0, 3'd5, 32'h02, 32'h0, 32'h8001_7FFF, 0);
        check("LHU result", core_rd_o, 32'h0000_8001);
        access(0, 3'd0, 32'h00, 32'h0, 32'h1234_5678, 0);
        check("LB pos result", core_rd_o, 32'h0000_0078);
        access(1, 3'd0, 32'h01, 32'hAB55, 32'h0, 0);
        access(1, 3'd2, 32'h0C, 32'h0BAD_CAFE, 32'h0, 2);
        access(0, 3'd1, 32'h01, 32'h0, 32'h0, 0);
        check("LH odd pulse", mis_cnt, 1);
        access(0, 3'd7, 32'h00, 32'h0, 32'h0, 0);
        check("size7 pulse", mis_cnt, 1);

        // Reset in the middle of an ACCESS that never completes.
        chk = 0;
        core_req_i = 1; core_we_i = 0; core_size_i = 3'd2; core_addr_i = 32'h80;
        step();
        step();
        check("pre-reset mem_req", mem_req_o, 1'b1);
        #2 rst_i = 1;
        #1;
        check("async rst mem_req", mem_req_o, 1'b0);
        check("async rst mem_addr", mem_addr_o, 32'd0);
        check("async rst mem_be", mem_be_o, 4'd0);
        check("async rst core_rd", core_rd_o, 32'd0);
        check("async rst bus_err", core_bus_err_o, 1'b0);
        core_req_i = 0;
        step();
        rst_i = 0;
        last_rd = 0; exp_rd = 0; exp_idle();
        chk = 1;
        step();
        access(0, 3'd2, 32'h84, 32'h0, 32'h0F0F_A5A5, 0);
        check("post-reset LW", core_rd_o, 32'h0F0F_A5A5);
        check("post-reset err", err_cnt, 0);

        chk = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
